// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ex/ls writeback requests onto one registered register-file write port.
// Optional starvation guard for ex is enabled by defining WB_STARVE_EN.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_rd,
   input  logic [31:0] ex_data,
   input  logic        ls_valid,
   output logic        ls_ready,
   input  logic [31:0] ls_rd,
   input  logic [31:0] ls_data,
   output logic        rf_wen,
   output logic [31:0] rf_wraddr,
   output logic [31:0] rf_wrdata,
   output logic        busy
);
   typedef enum logic {LS_PRI, EX_PRI} arb_e;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end

   arb_e        arb;
   logic        ex_go, ls_go, ex_wr, ls_wr;
   logic        rf_wen_q, rf_wen_d;
   logic [31:0] rf_wraddr_q, rf_wraddr_d, rf_wrdata_q, rf_wrdata_d;
   logic        unused_rd_hi;

`ifdef WB_STARVE_EN
   logic [3:0] starve_q, starve_d;
   assign arb = (starve_q == 4'(STARVE_LIMIT)) ? EX_PRI : LS_PRI;
   always_comb
      starve_d = hold                         ? starve_q :
                 (!ex_valid || ex_ready)      ? 4'd0 :
                 (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) starve_q <= 4'd0;
      else        starve_q <= starve_d;
`else
   assign arb = LS_PRI;
`endif

   assign ex_ready = rst_n && !hold && ex_valid && (!ls_valid || arb == EX_PRI);
   assign ls_ready = rst_n && !hold && ls_valid && !(ex_valid && arb == EX_PRI);
   assign ex_go    = ex_valid && ex_ready;
   assign ls_go    = ls_valid && ls_ready;
   // rd==0 transfers are accepted but never reach the register file
   assign ex_wr    = ex_go && (ex_rd[4:0] != 5'd0);
   assign ls_wr    = ls_go && (ls_rd[4:0] != 5'd0);
   assign unused_rd_hi = ^{ex_rd[31:5], ls_rd[31:5]};

   always_comb begin
      rf_wen_d    = hold ? rf_wen_q : (ex_wr || ls_wr);
      rf_wraddr_d = ex_wr ? {27'd0, ex_rd[4:0]} : ls_wr ? {27'd0, ls_rd[4:0]} : rf_wraddr_q;
      rf_wrdata_d = ex_wr ? ex_data : ls_wr ? ls_data : rf_wrdata_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rf_wen_q    <= 1'b0;
         rf_wraddr_q <= 32'd0;
         rf_wrdata_q <= 32'd0;
      end else begin
         rf_wen_q    <= rf_wen_d;
         rf_wraddr_q <= rf_wraddr_d;
         rf_wrdata_q <= rf_wrdata_d;
      end

   assign rf_wen    = rf_wen_q;
   assign rf_wraddr = rf_wraddr_q;
   assign rf_wrdata = rf_wrdata_q;
   assign busy      = rf_wen_q;
endmodule
